// File: rtl/gauss_run_ctrl_if.sv
// gauss_run_ctrl_if: start/status, AXI-lite config write channels and stream beat strobes of the run controller.
interface gauss_run_ctrl_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        awvalid;
    logic [4:0]  awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic        in_fire;
    logic        in_tlast;
    logic        out_fire;

    modport master (
        input  start, awready, wready, bvalid, in_fire, out_fire,
        output busy, done, err, awvalid, awaddr, wvalid, wdata, wstrb, bready, in_tlast
    );

    modport slave (
        output start, awready, wready, bvalid, in_fire, out_fire,
        input  busy, done, err, awvalid, awaddr, wvalid, wdata, wstrb, bready, in_tlast
    );
endinterface

// File: rtl/gauss_run_ctrl.sv
// gauss_run_ctrl: writes ap_start over AXI-lite, then counts one frame of in/out stream beats.
// Define GAUSS_RUN_CTRL_TIMEOUT_EN to add the idle watchdog and its ERR exit.
module gauss_run_ctrl #(
    parameter int FRAME_IN  = 1024,
    parameter int FRAME_OUT = 1024,
    parameter int TIMEOUT   = 4095
) (
    input logic             ap_clk,
    input logic             ap_rst_n,
    gauss_run_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, CFG, RESP, RUN, DONE, ERR} state_t;

    localparam logic [15:0] IN_MAX   = 16'(FRAME_IN);
    localparam logic [15:0] IN_LAST  = 16'(FRAME_IN - 1);
    localparam logic [15:0] OUT_MAX  = 16'(FRAME_OUT);
    localparam logic [15:0] OUT_LAST = 16'(FRAME_OUT - 1);

    state_t      state;
    logic [15:0] in_cnt, out_cnt;
    logic        busy_q, done_q, awvalid_q, wvalid_q, bready_q;
    logic        in_full, out_full, expired;

    // Look at the counts as they will be after this edge so DONE follows the final beat directly.
    assign in_full  = in_cnt == IN_MAX || (bus.in_fire && in_cnt == IN_LAST);
    assign out_full = out_cnt == OUT_MAX || (bus.out_fire && out_cnt == OUT_LAST);

`ifdef GAUSS_RUN_CTRL_TIMEOUT_EN
    logic [11:0] wd;
    logic        activity, watched, err_q;
    assign activity = bus.awready | bus.wready | bus.bvalid | bus.in_fire | bus.out_fire;
    assign watched  = state == CFG || state == RESP || state == RUN;
    assign expired  = watched && !activity && wd == 12'(TIMEOUT - 1);
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            wd    <= (watched && !activity && !expired) ? wd + 12'd1 : 12'd0;
            err_q <= (state == IDLE && bus.start) ? 1'b0 : (expired ? 1'b1 : err_q);
        end
    end
    assign bus.err = err_q;
`else
    assign expired = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (expired) begin
                state     <= ERR;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        state     <= CFG;
                        busy_q    <= 1'b1;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                    end
                    CFG: begin
                        if (bus.awready) awvalid_q <= 1'b0;
                        if (bus.wready) wvalid_q <= 1'b0;
                        if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) begin
                            state    <= RESP;
                            bready_q <= 1'b1;
                        end
                    end
                    RESP: if (bus.bvalid) begin
                        state    <= RUN;
                        bready_q <= 1'b0;
                    end
                    RUN: begin
                        in_cnt  <= in_cnt + {15'd0, bus.in_fire && in_cnt != IN_MAX};
                        out_cnt <= out_cnt + {15'd0, bus.out_fire && out_cnt != OUT_MAX};
                        if (in_full && out_full) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.awvalid  = awvalid_q;
    assign bus.awaddr   = 5'h00;
    assign bus.wvalid   = wvalid_q;
    assign bus.wdata    = wvalid_q ? 32'h1 : 32'h0;
    assign bus.wstrb    = wvalid_q ? 4'hF : 4'h0;
    assign bus.bready   = bready_q;
    assign bus.in_tlast = state == RUN && in_cnt == IN_LAST;
endmodule
